joy_db9_scanner: RTL and testbench
==================================

Name: joy_db9_scanner

Overview:
- Master-side sequencer for the DB9/JAMMA serial joystick chain on Neptuno-class boards: parallel-load shift register read through JOY_LOAD/JOY_CLK/JOY_DATA, with the two DB9 ports multiplexed by JOY_SELECT.
- Generates load, clock and select timing itself instead of forwarding an external master.
- Deserialises each frame and presents two debounce-capable, active-high joystick words to the core.

Parameters:
- CLK_DIV, 4, clk cycles per scan tick; legal range 2..255.
- NBITS, 12, bits shifted per frame (per port); legal range 1..16.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  1 = run continuous scanning; 0 = stop after the current frame.
- joy_data  in  1  serial data from the shift register; active-low buttons.
- joy_clk  out  1  shift clock to the chain.
- joy_load_n  out  1  parallel-load strobe, active low.
- joy_select  out  1  port select; 1 = port A, 0 = port B.
- joy_a  out  NBITS  port A buttons, active high; bit i = i-th shifted bit.
- joy_b  out  NBITS  port B buttons, active high.
- frame_done  out  1  one-clk pulse when a frame is committed.
- busy  out  1  high while not in IDLE.

Behaviour:
- Reset: all registers clear asynchronously while rst_n=0.
  - Output reset values: joy_clk=0, joy_load_n=1, joy_select=1, joy_a=0, joy_b=0, frame_done=0, busy=0.
  - State=IDLE; divider=0; bit index=0.
- Divider: counts 0..CLK_DIV-1 and wraps. tick=1 for one clk when the count equals CLK_DIV-1. The FSM changes state only on tick.
- FSM; all outputs are registered:
  - IDLE: joy_load_n=1, joy_clk=0. On tick with enable=1, go to LOAD.
  - LOAD: joy_load_n=0 for exactly one tick. On tick, set joy_load_n=1, idx=0, go to LOW.
  - LOW: joy_clk=0. On tick, shreg[idx]<=joy_data, set joy_clk=1, go to HIGH.
  - HIGH: on tick, set joy_clk=0.
    - If idx==NBITS-1, go to DONE.
    - Otherwise idx<=idx+1 and go to LOW.
  - DONE: on tick, commit ~shreg to joy_a if joy_select=1, else to joy_b.
    - Toggle joy_select and pulse frame_done for 1 clk.
    - Go to IDLE.
- Sampling point: data is sampled at the end of the clk-low phase, i.e. just before the joy_clk rising edge. Bit 0 is the value present right after load.
- Frame length: IDLE 1 + LOAD 1 + 2*NBITS + DONE 1 ticks, i.e. (2*NBITS+3)*CLK_DIV clk. Default = 27*4 = 108 clk.
- joy_select changes only in DONE, so it is stable for at least 1 tick before the next LOAD.
- Ports alternate strictly A, B, A, B... starting with A after reset.
- enable dropped mid-frame: the frame completes and commits normally, then the FSM stays in IDLE. Re-asserting enable resumes with the port indicated by joy_select.
- enable is sampled only in IDLE.
- Reset asserted mid-frame: immediate return to reset values. A partial shreg is never committed.
- busy = (state != IDLE).
- joy_a and joy_b hold their values between commits.

Optional Feature:
- Macro: JOY_DEBOUNCE_EN.
- Defined:
  - Each port keeps last_raw[NBITS], reset to all-ones (released).
  - In DONE, the output word updates only if ~shreg equals ~last_raw for that port. last_raw is updated on every DONE.
  - frame_done pulses on every DONE regardless.
  - A change therefore appears on the second consecutive identical frame of that port.
- Undefined: every frame commits directly; the last_raw registers are not built.

Test Plan:
- Reset and idle: hold rst_n=0, then release with enable=0 for 500 clk -> joy_load_n=1, joy_clk=0, joy_select=1, busy=0, joy_a=joy_b=0, no frame_done.
- Timing check: enable=1, defaults -> first joy_load_n low pulse lasts 4 clk; 12 joy_clk high pulses of 4 clk each; frame_done pulses 108 clk after the first frame start, then every 108 clk.
- Data path: model drives port A pattern 12'b1111_0101_1110 (bit0 first) and port B all-ones -> joy_a=12'b0000_1010_0001 after the first frame_done; joy_b=0 after the second.
- Select alternation: observe 4 frames -> joy_select sequence during LOAD is 1, 0, 1, 0; commits go to joy_a, joy_b, joy_a, joy_b.
- Stop and mid-frame reset: drop enable during bit 5 -> frame completes, busy falls, no further LOAD. Separately, assert rst_n=0 during bit 7 -> outputs return to reset values and no commit occurs.
- Debounce (JOY_DEBOUNCE_EN): port A bit3 pressed for one A-frame only -> joy_a stays 0. Pressed for two consecutive A-frames -> joy_a[3]=1 after the second A commit. Without the macro, the single frame sets joy_a[3]=1 immediately.

Source files
------------

// File: rtl/joy_db9_scanner.sv
// joy_db9_scanner
//   Master-side sequencer for a DB9/JAMMA serial joystick chain built from a
//   parallel-load shift register. It generates load, shift clock and port
//   select timing, deserialises each frame and presents two active-high
//   joystick words. Ports are read strictly A, B, A, B... starting with A.
//
//   Optional build macro: JOY_DEBOUNCE_EN
//     When defined, a port's output word only updates when two consecutive
//     frames of that port carry identical data.
//
// Parameters
//   CLK_DIV    clk cycles per scan tick (2..255)
//   NBITS      bits shifted per frame, per port (1..16)
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   enable     1 = scan continuously, 0 = stop after the current frame
//   joy_data   serial data from the chain, active-low buttons
//   joy_clk    shift clock to the chain
//   joy_load_n parallel-load strobe, active low
//   joy_select port select, 1 = port A, 0 = port B
//   joy_a      port A buttons, active high, bit i = i-th shifted bit
//   joy_b      port B buttons, active high
//   frame_done one-clk pulse when a frame is committed
//   busy       high while the sequencer is not idle
//
// Chain handshake: there is no back-pressure. Every signal towards the chain
// is registered and changes only on a scan tick; joy_data is sampled on the
// tick that ends the low phase of joy_clk, just before its rising edge.
module joy_db9_scanner #(
    parameter int CLK_DIV = 4,
    parameter int NBITS   = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             joy_data,
    output logic             joy_clk,
    output logic             joy_load_n,
    output logic             joy_select,
    output logic [NBITS-1:0] joy_a,
    output logic [NBITS-1:0] joy_b,
    output logic             frame_done,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LOW,
        S_HIGH,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       div_q;
    logic [3:0]       idx_q, idx_d;
    logic [NBITS-1:0] shreg_q, shreg_d;
    logic             clk_q, clk_d;
    logic             load_n_q, load_n_d;
    logic             sel_q, sel_d;
    logic [NBITS-1:0] a_q, a_d;
    logic [NBITS-1:0] b_q, b_d;
    logic             done_q, done_d;
    logic             tick;

`ifdef JOY_DEBOUNCE_EN
    // Raw (active-low) data of the previous frame of each port.
    logic [NBITS-1:0] last_a_q, last_a_d;
    logic [NBITS-1:0] last_b_q, last_b_d;
`endif

    assign tick = (div_q == 8'(CLK_DIV - 1));

    // Free-running scan tick divider.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else if (tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 8'd1;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shreg_d  = shreg_q;
        clk_d    = clk_q;
        load_n_d = load_n_q;
        sel_d    = sel_q;
        a_d      = a_q;
        b_d      = b_q;
        done_d   = 1'b0;
`ifdef JOY_DEBOUNCE_EN
        last_a_d = last_a_q;
        last_b_d = last_b_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (tick && enable) begin
                    load_n_d = 1'b0;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                if (tick) begin
                    load_n_d = 1'b1;
                    idx_d    = '0;
                    state_d  = S_LOW;
                end
            end
            S_LOW: begin
                if (tick) begin
                    for (int i = 0; i < NBITS; i++) begin
                        if (idx_q == 4'(i)) begin
                            shreg_d[i] = joy_data;
                        end
                    end
                    clk_d   = 1'b1;
                    state_d = S_HIGH;
                end
            end
            S_HIGH: begin
                if (tick) begin
                    clk_d = 1'b0;
                    if (idx_q == 4'(NBITS - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = S_LOW;
                    end
                end
            end
            S_DONE: begin
                if (tick) begin
`ifdef JOY_DEBOUNCE_EN
                    if (sel_q) begin
                        if (shreg_q == last_a_q) a_d = ~shreg_q;
                        last_a_d = shreg_q;
                    end else begin
                        if (shreg_q == last_b_q) b_d = ~shreg_q;
                        last_b_d = shreg_q;
                    end
`else
                    if (sel_q) a_d = ~shreg_q;
                    else       b_d = ~shreg_q;
`endif
                    sel_d   = ~sel_q;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            shreg_q  <= '0;
            clk_q    <= 1'b0;
            load_n_q <= 1'b1;
            sel_q    <= 1'b1;
            a_q      <= '0;
            b_q      <= '0;
            done_q   <= 1'b0;
`ifdef JOY_DEBOUNCE_EN
            last_a_q <= '1;
            last_b_q <= '1;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            shreg_q  <= shreg_d;
            clk_q    <= clk_d;
            load_n_q <= load_n_d;
            sel_q    <= sel_d;
            a_q      <= a_d;
            b_q      <= b_d;
            done_q   <= done_d;
`ifdef JOY_DEBOUNCE_EN
            last_a_q <= last_a_d;
            last_b_q <= last_b_d;
`endif
        end
    end

    assign joy_clk    = clk_q;
    assign joy_load_n = load_n_q;
    assign joy_select = sel_q;
    assign joy_a      = a_q;
    assign joy_b      = b_q;
    assign frame_done = done_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_joy_db9_scanner.sv
// tb_joy_db9_scanner
//   Bench for joy_db9_scanner. A behavioural shift-register chain supplies
//   joy_data; each parallel load pushes the predicted commit into exp_q and a
//   monitor pops and compares on every frame_done. Timing of load, shift
//   clock and frame length is measured by the same monitor.
module tb_joy_db9_scanner;
    localparam int NBITS   = 12;
    localparam int CLK_DIV = 4;
    localparam int W       = NBITS + 1;
    localparam int FRAME   = (2 * NBITS + 3) * CLK_DIV;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             enable = 1'b0;
    logic             joy_data;
    logic             joy_clk, joy_load_n, joy_select, frame_done, busy;
    logic [NBITS-1:0] joy_a, joy_b;

    always #5 clk = ~clk;

    joy_db9_scanner #(.CLK_DIV(CLK_DIV), .NBITS(NBITS)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .joy_data(joy_data),
        .joy_clk(joy_clk), .joy_load_n(joy_load_n), .joy_select(joy_select),
        .joy_a(joy_a), .joy_b(joy_b), .frame_done(frame_done), .busy(busy)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Chain model: button levels per port (active low), loaded on the falling
    // edge of joy_load_n and shifted towards bit 0 on each joy_clk rise.
    logic [NBITS-1:0] pat_a = '1, pat_b = '1;
    logic [NBITS-1:0] dev_word = '1;
    assign joy_data = dev_word[0];

    // Reference model state.
    logic [W-1:0]     exp_q[$];
    logic [NBITS-1:0] mod_last_a, mod_last_b, mod_out_a, mod_out_b;
    logic [NBITS-1:0] com_a, com_b;
    logic             exp_sel;

    function automatic logic [NBITS-1:0] predict(input logic [NBITS-1:0] raw,
                                                  input logic [NBITS-1:0] last,
                                                  input logic [NBITS-1:0] prev_out);
`ifdef JOY_DEBOUNCE_EN
        return (raw == last) ? ~raw : prev_out;
`else
        return (last == last) ? ~raw : prev_out;
`endif
    endfunction

    int cyc = 0, load_cyc = 0, jclk_rise = 0, jclk_cnt = 0;
    int loads = 0, done_cnt = 0;
    int done_hist[$];
    logic prev_load_n = 1'b1, prev_jclk = 1'b0, prev_done = 1'b0;

    always @(posedge clk) begin
        logic [W-1:0]     e;
        logic [NBITS-1:0] p;
        logic             s;
        #1;
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            mod_last_a = '1; mod_last_b = '1;
            mod_out_a  = '0; mod_out_b  = '0;
            com_a = '0; com_b = '0;
            exp_sel = 1'b1;
            dev_word = '1;
            jclk_cnt = 0;
            prev_load_n = 1'b1; prev_jclk = 1'b0; prev_done = 1'b0;
        end else begin
            if (prev_load_n && !joy_load_n) begin
                check("load_select", {31'b0, joy_select}, {31'b0, exp_sel});
                dev_word = joy_select ? pat_a : pat_b;
                if (exp_sel) begin
                    p = predict(pat_a, mod_last_a, mod_out_a);
                    mod_last_a = pat_a; mod_out_a = p;
                end else begin
                    p = predict(pat_b, mod_last_b, mod_out_b);
                    mod_last_b = pat_b; mod_out_b = p;
                end
                exp_q.push_back({exp_sel, p});
                exp_sel = ~exp_sel;
                load_cyc = cyc;
                jclk_cnt = 0;
                loads++;
            end
            if (!prev_load_n && joy_load_n)
                check("load_width", cyc - load_cyc, CLK_DIV);
            if (!prev_jclk && joy_clk) begin
                dev_word = {1'b1, dev_word[NBITS-1:1]};
                jclk_cnt++;
                jclk_rise = cyc;
                check("busy_shift", {31'b0, busy}, 1);
            end
            if (prev_jclk && !joy_clk)
                check("clk_high_width", cyc - jclk_rise, CLK_DIV);
            if (prev_done && frame_done)
                check("done_width", 2, 1);
            if (frame_done) begin
                done_cnt++;
                done_hist.push_back(cyc);
                check("frame_len", cyc - load_cyc, (2 * NBITS + 2) * CLK_DIV);
                check("clk_pulses", jclk_cnt, NBITS);
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    if (e[NBITS]) com_a = e[NBITS-1:0];
                    else          com_b = e[NBITS-1:0];
                    s = ~e[NBITS];
                    check("commit_joy_a", 32'(joy_a), 32'(com_a));
                    check("commit_joy_b", 32'(joy_b), 32'(com_b));
                    check("commit_select", {31'b0, joy_select}, {31'b0, s});
                end
            end
            prev_load_n = joy_load_n;
            prev_jclk   = joy_clk;
            prev_done   = frame_done;
        end
    end

    task automatic wait_frames(input int n);
        int target = done_cnt + n;
        int budget = n * FRAME * 2 + 50;
        while (done_cnt < target && budget > 0) begin
            @(posedge clk); #2;
            budget--;
        end
        if (done_cnt < target) check("wait_frames_timeout", done_cnt, target);
    endtask

    // Returns just after a port A commit (select has flipped to B).
    task automatic wait_a_commit();
        wait_frames(1);
        if (joy_select) wait_frames(1);
    endtask

    task automatic wait_bit(input int k);
        int budget = 2 * FRAME;
        while (!(jclk_cnt == k && !joy_load_n == 1'b0 && busy) && budget > 0) begin
            @(posedge clk); #2;
            budget--;
        end
        if (budget == 0) check("wait_bit_timeout", jclk_cnt, k);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_joy_clk"},    {31'b0, joy_clk},    0);
        check({tag, "_joy_load_n"}, {31'b0, joy_load_n}, 1);
        check({tag, "_joy_select"}, {31'b0, joy_select}, 1);
        check({tag, "_joy_a"},      32'(joy_a),          0);
        check({tag, "_joy_b"},      32'(joy_b),          0);
        check({tag, "_frame_done"}, {31'b0, frame_done}, 0);
        check({tag, "_busy"},       {31'b0, busy},       0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int h, l, d;
        // Reset and idle.
        rst_n = 1'b0; enable = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check_reset_values("in_reset");
        rst_n = 1'b1;
        repeat (500) @(posedge clk);
        #2;
        check_reset_values("idle");
        check("idle_no_done", done_cnt, 0);
        check("idle_no_load", loads, 0);

        // Timing and directed data path.
        pat_a = 12'b1111_0101_1110;
        pat_b = '1;
        enable = 1'b1;
        h = done_hist.size();
        wait_frames(1);
`ifdef JOY_DEBOUNCE_EN
        check("first_joy_a", 32'(joy_a), 32'h000);
`else
        check("first_joy_a", 32'(joy_a), 32'(12'b0000_1010_0001));
`endif
        wait_frames(1);
        check("second_joy_b", 32'(joy_b), 0);
        wait_frames(2);
        if (done_hist.size() >= h + 4) begin
            for (int i = 1; i < 4; i++)
                check("frame_period", done_hist[h + i] - done_hist[h + i - 1], FRAME);
        end else begin
            check("frame_period_count", done_hist.size() - h, 4);
        end

        // Debounce: single-frame press versus two consecutive frames.
        wait_a_commit();
        pat_a = '1; pat_b = '1;
        wait_a_commit();
        wait_a_commit();
        check("db_base", 32'(joy_a), 0);
        pat_a = 12'hFF7;
        wait_a_commit();
`ifdef JOY_DEBOUNCE_EN
        check("db_single", 32'(joy_a), 32'h000);
`else
        check("db_single", 32'(joy_a), 32'h008);
`endif
        pat_a = '1;
        wait_a_commit();
        wait_a_commit();
        pat_a = 12'hFF7;
        wait_a_commit();
`ifdef JOY_DEBOUNCE_EN
        check("db_first", 32'(joy_a), 32'h000);
`else
        check("db_first", 32'(joy_a), 32'h008);
`endif
        wait_a_commit();
        check("db_second", 32'(joy_a), 32'h008);

        // Randomized frames; patterns sometimes repeat to exercise debounce.
        for (int i = 0; i < 10; i++) begin
            wait_frames(1);
            if ($urandom_range(0, 1) == 1) pat_a = NBITS'($urandom);
            if ($urandom_range(0, 1) == 1) pat_b = NBITS'($urandom);
        end

        // Drop enable in the middle of a frame.
        wait_bit(5);
        enable = 1'b0;
        wait_frames(1);
        l = loads; d = done_cnt;
        repeat (3 * FRAME) @(posedge clk);
        #2;
        check("stop_busy", {31'b0, busy}, 0);
        check("stop_no_load", loads, l);
        check("stop_no_done", done_cnt, d);
        check("stop_load_n", {31'b0, joy_load_n}, 1);

        // Resume continues with the port joy_select indicates.
        enable = 1'b1;
        wait_frames(3);

        // Reset in the middle of a frame.
        pat_a = NBITS'($urandom);
        wait_bit(7);
        rst_n = 1'b0;
        enable = 1'b0;
        #1;
        check_reset_values("mid_reset");
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        l = loads; d = done_cnt;
        repeat (300) @(posedge clk);
        #2;
        check("post_reset_no_done", done_cnt, d);
        check("post_reset_no_load", loads, l);
        check_reset_values("post_reset");

        // Scanning restarts with port A after reset.
        pat_a = NBITS'($urandom); pat_b = NBITS'($urandom);
        enable = 1'b1;
        wait_frames(2);
        enable = 1'b0;
        wait_frames(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
